// File: rtl/i2c_fifo_pkg.sv
// i2c_fifo_pkg: shared sizing constants for the I2C transmit/receive FIFO pair.
package i2c_fifo_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1;
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/i2c_sync_fifo.sv
// i2c_sync_fifo: single-clock first-word-fall-through FIFO with count, flags and error pulses.
module i2c_sync_fifo
  import i2c_fifo_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int DP = DEPTH,
  parameter int AW = ADDR_WIDTH,
  parameter int CW = CNT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);
  logic [DW-1:0] mem [DP];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty     = count == '0;
  assign full      = count == CW'(DP);
  // a pop on a full FIFO frees the slot the simultaneous push writes into
  assign do_push   = push && !clr && (!full || pop);
  assign do_pop    = pop && !clr && !empty;
  assign overflow  = push && !clr && full && !pop;
  assign underflow = pop && !clr && empty && !push;
  assign dout      = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/i2c_fifo_block.sv
// i2c_fifo_block: transmit and receive FIFOs in front of the I2C master, with sticky error flags.
module i2c_fifo_block
  import i2c_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = i2c_fifo_pkg::DATA_WIDTH,
  parameter int DEPTH      = i2c_fifo_pkg::DEPTH,
  parameter int ADDR_WIDTH = i2c_fifo_pkg::ADDR_WIDTH,
  parameter int CNT_WIDTH  = i2c_fifo_pkg::CNT_WIDTH
) (
  input  logic                  i2c_core_clock_i,
  input  logic                  reset_bit_i,
  input  logic                  flush_i,
  input  logic                  tx_wr_en_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_rd_en_i,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  trans_fifo_empty_o,
  output logic                  trans_fifo_full_o,
  output logic [CNT_WIDTH-1:0]  tx_count_o,
  output logic                  tx_overflow_o,
  input  logic                  rx_wr_en_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                  rx_rd_en_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rev_fifo_empty_o,
  output logic                  rev_fifo_full_o,
  output logic [CNT_WIDTH-1:0]  rx_count_o,
  output logic                  rx_underflow_o,
  output logic                  rx_overflow_o
);
  logic tx_ovf, tx_unused_udf, rx_ovf, rx_udf;
  i2c_sync_fifo #(.DW(DATA_WIDTH), .DP(DEPTH), .AW(ADDR_WIDTH), .CW(CNT_WIDTH)) u_tx (
    .clk(i2c_core_clock_i), .rst_n(reset_bit_i), .clr(flush_i),
    .push(tx_wr_en_i), .pop(tx_rd_en_i), .din(tx_data_i), .dout(tx_data_o),
    .empty(trans_fifo_empty_o), .full(trans_fifo_full_o), .count(tx_count_o),
    .overflow(tx_ovf), .underflow(tx_unused_udf)
  );
  i2c_sync_fifo #(.DW(DATA_WIDTH), .DP(DEPTH), .AW(ADDR_WIDTH), .CW(CNT_WIDTH)) u_rx (
    .clk(i2c_core_clock_i), .rst_n(reset_bit_i), .clr(flush_i),
    .push(rx_wr_en_i), .pop(rx_rd_en_i), .din(rx_data_i), .dout(rx_data_o),
    .empty(rev_fifo_empty_o), .full(rev_fifo_full_o), .count(rx_count_o),
    .overflow(rx_ovf), .underflow(rx_udf)
  );
  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i)
    if (!reset_bit_i) {tx_overflow_o, rx_overflow_o, rx_underflow_o} <= '0;
    else {tx_overflow_o, rx_overflow_o, rx_underflow_o} <= flush_i ? 3'b000 :
      {tx_overflow_o | tx_ovf, rx_overflow_o | rx_ovf, rx_underflow_o | rx_udf};
endmodule

// File: doc/i2c_fifo_block.md
Name: i2c_fifo_block

Overview:
Upstream buffer stage for the I2C master. It holds a transmit FIFO and a receive FIFO.
- The transmit FIFO is filled by the host register interface. It presents the head byte and the empty flag to the master's data_i and trans_fifo_empty_i inputs.
- The receive FIFO captures the master's data_o bytes. It reports its full flag to rev_fifo_full_i.
- Both FIFOs are single-clock, first-word-fall-through, and have sticky error flags.

Parameters:
DATA_WIDTH, 8, byte width of each entry
DEPTH, 16, entries per FIFO; must be a power of two, at least 2
ADDR_WIDTH, 4, log2(DEPTH); pointer width
CNT_WIDTH, 5, ADDR_WIDTH+1; occupancy count width

Ports:
i2c_core_clock_i  in  1  core clock; all logic on rising edge
reset_bit_i  in  1  asynchronous, active-low reset
flush_i  in  1  synchronous clear of both FIFOs and both error flags
tx_wr_en_i  in  1  host push into transmit FIFO
tx_data_i  in  DATA_WIDTH  host write data
tx_rd_en_i  in  1  master pop; one-cycle pulse when a byte has been loaded for transfer
tx_data_o  out  DATA_WIDTH  head of transmit FIFO; drives the master's data_i
trans_fifo_empty_o  out  1  transmit FIFO empty
trans_fifo_full_o  out  1  transmit FIFO full
tx_count_o  out  CNT_WIDTH  transmit occupancy
tx_overflow_o  out  1  sticky: host push while full was dropped
rx_wr_en_i  in  1  master push; one-cycle pulse when a received byte is complete
rx_data_i  in  DATA_WIDTH  received byte from the master's data_o
rx_rd_en_i  in  1  host pop from receive FIFO
rx_data_o  out  DATA_WIDTH  head of receive FIFO
rev_fifo_empty_o  out  1  receive FIFO empty
rev_fifo_full_o  out  1  receive FIFO full
rx_count_o  out  CNT_WIDTH  receive occupancy
rx_underflow_o  out  1  sticky: host pop while empty was ignored
rx_overflow_o  out  1  sticky: master push while full was dropped

Behaviour:
Reset values (reset_bit_i = 0, applied asynchronously):
- All pointers and counts are 0.
- trans_fifo_empty_o = 1 and rev_fifo_empty_o = 1.
- Both full flags are 0.
- All sticky error flags are 0.
- tx_data_o and rx_data_o are 0. Memory contents are not reset.
- Reset mid-transfer discards all contents immediately.

Each FIFO behaves identically:
- Storage is a DEPTH-entry array with ADDR_WIDTH-bit read and write pointers that wrap modulo DEPTH.
- The count is a CNT_WIDTH-bit register. empty = (count == 0); full = (count == DEPTH). Both are decoded from registered count, so they are glitch-free.
- The data output is memory[rd_ptr] when count != 0, otherwise 0. This is first-word fall-through.
- Timing: a push at edge N makes the byte visible on the data output, and deasserts empty, after edge N. Latency is 1 cycle.
- A pop at edge N advances rd_ptr. The next entry is visible after edge N.

Per-cycle cases for each FIFO:
- Push only, not full: write memory[wr_ptr], wr_ptr+1, count+1.
- Push only, full: data dropped; the FIFO's overflow flag is set; pointers unchanged.
- Pop only, not empty: rd_ptr+1, count-1.
- Pop only, empty: ignored. rx_underflow_o is set for the receive FIFO. On the transmit side the pop is silently ignored; the master guarantees no pop while trans_fifo_empty_o = 1.
- Push and pop, count strictly between 0 and DEPTH: both occur; count unchanged.
- Push and pop, empty: push only; count becomes 1; no underflow flag.
- Push and pop, full: both occur; count stays DEPTH; no overflow flag.

Other rules:
- flush_i has priority over push and pop in the same cycle. It returns both FIFOs to the reset state; memory is untouched.
- Sticky flags clear only on reset or flush_i.
- There is no combinational path from any *_en_i input to any output.

Decomposition:
- Package i2c_fifo_pkg holds DATA_WIDTH, DEPTH, ADDR_WIDTH and CNT_WIDTH defaults, plus a count-width helper constant.
- One sub-module, i2c_sync_fifo: a single generic FIFO with push/pop, count, full/empty and overflow/underflow pulse outputs.
- i2c_fifo_block instantiates i2c_sync_fifo twice and owns the sticky flag registers and the flush distribution.

Test Plan:
1. Reset, then check idle outputs: both empty = 1, both counts = 0, all flags = 0, tx_data_o = 0.
2. Push 0xA5, 0x3C into transmit:
   - After the first edge, tx_data_o = 0xA5 and trans_fifo_empty_o = 0.
   - Pop: tx_data_o = 0x3C, tx_count_o = 1.
   - Pop: trans_fifo_empty_o = 1.
3. Fill the receive FIFO with 16 bytes 0x00..0x0F:
   - rev_fifo_full_o = 1 and rx_count_o = 16.
   - A 17th push of 0xFF sets rx_overflow_o; the 16 pops then return 0x00..0x0F in order.
   - A further pop sets rx_underflow_o.
4. Wrap-around and simultaneous push/pop:
   - Run 40 pushes and 40 pops interleaved at count = 8, with push and pop in the same cycle.
   - Count stays 8 throughout; the output sequence matches the input order across pointer wrap.
5. Simultaneous push/pop at the boundaries:
   - Empty transmit FIFO: count becomes 1 and tx_data_o equals the pushed byte.
   - Full transmit FIFO: count stays 16 and tx_overflow_o stays 0.
6. Reset and flush mid-operation:
   - Assert reset_bit_i low mid-stream at count = 5, asynchronously between clock edges. Outputs return to reset values before the next edge.
   - Separately, assert flush_i together with a push: count becomes 0 and the flags clear.
